// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: bus widths, enable levels, FSM states and stall codes shared by the fetch sequencer.
package fetch_ctrl_pkg;
    localparam int InstAddrBus = 32;
    localparam int InstBus = 32;
    localparam logic RstEnable = 1'b0;
    localparam logic ChipEnable = 1'b1;
    localparam logic ChipDisable = 1'b0;
    typedef enum logic [2:0] {S_RESET, S_IDLE, S_FETCH, S_HOLD, S_FLUSH} state_t;
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_FETCH = 6'b000011;
    localparam logic [5:0] STALL_ID = 6'b000111;
    localparam logic [5:0] STALL_EX = 6'b001111;
endpackage

// File: rtl/fetch_stall_enc.sv
// fetch_stall_enc: priority-encodes EX/ID stall requests and the fetch wait into the 6-bit stall code.
module fetch_stall_enc
    import fetch_ctrl_pkg::*;
(
    input  logic       stall_req_id,
    input  logic       stall_req_ex,
    input  logic       fetch_wait,
    output logic [5:0] code
);
    always_comb code = stall_req_ex ? STALL_EX : stall_req_id ? STALL_ID : fetch_wait ? STALL_FETCH : STALL_NONE;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC/ROM fetch sequencer with branch redirect and stall handling; FETCH_TIMEOUT_EN adds a sticky ROM timeout.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int DATA_W = InstBus,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_req_id,
    input  logic              stall_req_ex,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target_addr,
    input  logic              rom_rdy,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    output logic [5:0]        stall,
    output logic              fetch_err
);
    state_t state, nxt;
    logic pipe_stall, busy, take, timed_out, ce_nxt, valid_nxt;
    logic [ADDR_W-1:0] tgt, pc_nxt;
    logic [5:0] stall_code;
    assign pipe_stall = stall_req_id | stall_req_ex;
    assign busy = state == S_FETCH || state == S_FLUSH;
    assign take = state == S_FETCH && rom_rdy && !branch_flag;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic err;
    assign timed_out = busy && !rom_rdy && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk)
        if (rst == RstEnable) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (busy && !rom_rdy && !timed_out) ? cnt + 1'b1 : '0;
            err <= err | timed_out;
        end
    assign fetch_err = err;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
    assign timed_out = 1'b0;
    assign fetch_err = 1'b0;
`endif
    always_ff @(posedge clk)
        if (rst == RstEnable) state <= S_RESET;
        else state <= nxt;
    always_comb begin
        nxt = state;
        unique case (state)
            S_RESET: nxt = pipe_stall ? S_IDLE : S_FETCH;
            S_IDLE:  nxt = (fetch_err || pipe_stall) ? S_IDLE : S_FETCH;
            S_FETCH: nxt = timed_out ? S_IDLE : !rom_rdy ? (branch_flag ? S_FLUSH : S_FETCH) : pipe_stall ? (branch_flag ? S_IDLE : S_HOLD) : S_FETCH;
            S_HOLD:  nxt = pipe_stall ? (branch_flag ? S_IDLE : S_HOLD) : S_FETCH;
            S_FLUSH: nxt = timed_out ? S_IDLE : rom_rdy ? (pipe_stall ? S_IDLE : S_FETCH) : S_FLUSH;
            default: nxt = S_RESET;
        endcase
    end
    // A waiting request pins pc; a pending redirect is parked in tgt until the ROM acks.
    always_comb begin
        pc_nxt = pc;
        if (take) pc_nxt = pc + ADDR_W'(4);
        else if (branch_flag && state != S_RESET && !(busy && !rom_rdy) && !fetch_err) pc_nxt = branch_target_addr;
        else if (state == S_FLUSH && rom_rdy) pc_nxt = tgt;
    end
    always_comb begin
        ce_nxt = (nxt == S_FETCH || nxt == S_FLUSH) ? ChipEnable : ChipDisable;
        valid_nxt = (take && !pipe_stall) || (state == S_HOLD && !pipe_stall && !branch_flag);
    end
    fetch_stall_enc u_enc (
        .stall_req_id(stall_req_id),
        .stall_req_ex(stall_req_ex),
        .fetch_wait  ((busy && !rom_rdy) || fetch_err),
        .code        (stall_code)
    );
    always_ff @(posedge clk)
        if (rst == RstEnable) begin
            pc <= RESET_PC;
            tgt <= RESET_PC;
            ce <= ChipDisable;
            inst_o <= '0;
            inst_pc <= '0;
            inst_valid <= 1'b0;
            stall <= STALL_NONE;
        end else begin
            pc <= pc_nxt;
            tgt <= branch_flag ? branch_target_addr : tgt;
            ce <= ce_nxt;
            inst_valid <= valid_nxt;
            stall <= stall_code;
            if (take) begin
                inst_o <= rom_data;
                inst_pc <= pc;
            end
        end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenario tests for fetch_ctrl against hand-computed expectations.
module tb_fetch_ctrl;
    logic clk = 0, rst = 0, stall_req_id = 0, stall_req_ex = 0, branch_flag = 0;
    logic [31:0] branch_target_addr = 0;
    logic auto_rdy = 0, man_rdy = 0;
    logic rom_rdy, ce, inst_valid, fetch_err;
    logic [31:0] rom_data, pc, inst_o, inst_pc;
    logic [5:0] stall;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hA5A55A5A;
    endfunction

    assign rom_rdy = auto_rdy ? ce : man_rdy;
    assign rom_data = rom_word(pc);

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall_req_id(stall_req_id), .stall_req_ex(stall_req_ex),
        .branch_flag(branch_flag), .branch_target_addr(branch_target_addr),
        .rom_rdy(rom_rdy), .rom_data(rom_data), .pc(pc), .ce(ce), .inst_o(inst_o),
        .inst_pc(inst_pc), .inst_valid(inst_valid), .stall(stall), .fetch_err(fetch_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        tick(); tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h exp 00000000", pc); end
        checks++; if (ce !== 1'b0) begin failures++; $display("FAIL reset_ce: got %b exp 0", ce); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", inst_valid); end
        checks++; if (stall !== 6'b0) begin failures++; $display("FAIL reset_stall: got %b exp 000000", stall); end
        checks++; if (inst_o !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h/%h exp 0/0", inst_o, inst_pc); end
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", fetch_err); end
    endtask

    task automatic test_zero_wait();
        rst = 1; auto_rdy = 1;
        checks++; if (ce !== 1'b0) begin failures++; $display("FAIL rel_ce_low: got %b exp 0", ce); end
        tick();
        checks++; if (ce !== 1'b1 || pc !== 32'h0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rel_ce_rise: ce=%b pc=%h v=%b exp 1/0/0", ce, pc, inst_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst_o !== rom_word(32'(4 * i))) begin
                failures++; $display("FAIL zw_seq%0d: v=%b pc=%h inst=%h exp 1/%h/%h", i, inst_valid, inst_pc, inst_o, 32'(4 * i), rom_word(32'(4 * i)));
            end
        end
    endtask

    task automatic test_latency();
        auto_rdy = 0; man_rdy = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h10 || ce !== 1'b1 || inst_valid !== 1'b0 || stall !== 6'b000011) begin
                failures++; $display("FAIL lat_wait%0d: pc=%h ce=%b v=%b st=%b exp 10/1/0/000011", i, pc, ce, inst_valid, stall);
            end
        end
        man_rdy = 1;
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst_o !== rom_word(32'h10) || pc !== 32'h14 || stall !== 6'b0) begin
            failures++; $display("FAIL lat_done: v=%b ipc=%h inst=%h pc=%h st=%b exp 1/10/%h/14/000000", inst_valid, inst_pc, inst_o, pc, stall, rom_word(32'h10));
        end
    endtask

    task automatic test_stall_hold();
        stall_req_ex = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ce !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h18 || stall !== 6'b001111) begin
                failures++; $display("FAIL hold%0d: ce=%b v=%b pc=%h st=%b exp 0/0/18/001111", i, ce, inst_valid, pc, stall);
            end
        end
        stall_req_ex = 0; man_rdy = 0;
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h14 || inst_o !== rom_word(32'h14) || ce !== 1'b1 || stall !== 6'b0) begin
            failures++; $display("FAIL hold_release: v=%b ipc=%h inst=%h ce=%b st=%b exp 1/14/%h/1/000000", inst_valid, inst_pc, inst_o, ce, stall, rom_word(32'h14));
        end
        tick();
        checks++; if (inst_valid !== 1'b0 || stall !== 6'b000011 || pc !== 32'h18) begin
            failures++; $display("FAIL hold_nodup: v=%b st=%b pc=%h exp 0/000011/18", inst_valid, stall, pc);
        end
    endtask

    task automatic test_id_stall();
        stall_req_id = 1;
        tick();
        checks++; if (stall !== 6'b000111 || ce !== 1'b1 || pc !== 32'h18) begin
            failures++; $display("FAIL id_wait: st=%b ce=%b pc=%h exp 000111/1/18", stall, ce, pc);
        end
        man_rdy = 1;
        tick();
        checks++; if (ce !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h1C || stall !== 6'b000111) begin
            failures++; $display("FAIL id_hold: ce=%b v=%b pc=%h st=%b exp 0/0/1c/000111", ce, inst_valid, pc, stall);
        end
        stall_req_id = 0; man_rdy = 0;
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h18 || ce !== 1'b1) begin
            failures++; $display("FAIL id_release: v=%b ipc=%h ce=%b exp 1/18/1", inst_valid, inst_pc, ce);
        end
    endtask

    task automatic test_branch();
        branch_flag = 1; branch_target_addr = 32'h100;
        tick();
        checks++; if (pc !== 32'h1C || ce !== 1'b1 || stall !== 6'b000011 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL br_flush: pc=%h ce=%b st=%b v=%b exp 1c/1/000011/0", pc, ce, stall, inst_valid);
        end
        branch_flag = 0; branch_target_addr = 32'h0; man_rdy = 1;
        tick();
        checks++; if (pc !== 32'h100 || inst_valid !== 1'b0 || inst_pc !== 32'h18 || ce !== 1'b1) begin
            failures++; $display("FAIL br_discard: pc=%h v=%b ipc=%h ce=%b exp 100/0/18/1", pc, inst_valid, inst_pc, ce);
        end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_o !== rom_word(32'h100) || pc !== 32'h104) begin
            failures++; $display("FAIL br_target: v=%b ipc=%h inst=%h pc=%h exp 1/100/%h/104", inst_valid, inst_pc, inst_o, pc, rom_word(32'h100));
        end
        branch_flag = 1; branch_target_addr = 32'h200;
        tick();
        checks++; if (pc !== 32'h200 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL br_same_rdy: pc=%h v=%b exp 200/0", pc, inst_valid);
        end
        branch_flag = 0;
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || pc !== 32'h204) begin
            failures++; $display("FAIL br_same_next: v=%b ipc=%h pc=%h exp 1/200/204", inst_valid, inst_pc, pc);
        end
        branch_flag = 1; branch_target_addr = 32'hFFFFFFFC;
        tick();
        branch_flag = 0;
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFFFFFC || pc !== 32'h0) begin
            failures++; $display("FAIL pc_wrap: v=%b ipc=%h pc=%h exp 1/fffffffc/0", inst_valid, inst_pc, pc);
        end
    endtask

    task automatic test_branch_idle();
        stall_req_ex = 1;
        tick();
        branch_flag = 1; branch_target_addr = 32'h40;
        tick();
        checks++; if (pc !== 32'h40 || ce !== 1'b0 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL brh_idle: pc=%h ce=%b v=%b exp 40/0/0", pc, ce, inst_valid);
        end
        branch_flag = 0; stall_req_ex = 0;
        tick();
        checks++; if (ce !== 1'b1 || inst_valid !== 1'b0 || pc !== 32'h40) begin
            failures++; $display("FAIL brh_resume: ce=%b v=%b pc=%h exp 1/0/40", ce, inst_valid, pc);
        end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
            failures++; $display("FAIL brh_fetch: v=%b ipc=%h exp 1/40", inst_valid, inst_pc);
        end
    endtask

    task automatic test_reset_midfetch();
        man_rdy = 0;
        tick();
        rst = 0;
        tick();
        checks++; if (ce !== 1'b0 || pc !== 32'h0 || inst_valid !== 1'b0 || stall !== 6'b0) begin
            failures++; $display("FAIL mid_reset: ce=%b pc=%h v=%b st=%b exp 0/0/0/000000", ce, pc, inst_valid, stall);
        end
        rst = 1; man_rdy = 1;
        tick();
        checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || ce !== 1'b1 || pc !== 32'h0) begin
            failures++; $display("FAIL late_rdy: v=%b ipc=%h ce=%b pc=%h exp 0/0/1/0", inst_valid, inst_pc, ce, pc);
        end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            failures++; $display("FAIL post_reset_fetch: v=%b ipc=%h exp 1/0", inst_valid, inst_pc);
        end
    endtask

    task automatic test_timeout();
        man_rdy = 0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        checks++; if (ce !== 1'b1 || fetch_err !== 1'b0) begin failures++; $display("FAIL to_before: ce=%b err=%b exp 1/0", ce, fetch_err); end
        tick();
        checks++; if (ce !== 1'b0 || fetch_err !== 1'b1 || stall !== 6'b000011) begin
            failures++; $display("FAIL to_fire: ce=%b err=%b st=%b exp 0/1/000011", ce, fetch_err, stall);
        end
        man_rdy = 1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (ce !== 1'b0 || fetch_err !== 1'b1 || stall !== 6'b000011 || pc !== 32'h4) begin
            failures++; $display("FAIL to_sticky: ce=%b err=%b st=%b pc=%h exp 0/1/000011/4", ce, fetch_err, stall, pc);
        end
        rst = 0;
        tick();
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL to_clear: err=%b exp 0", fetch_err); end
`else
        for (int i = 0; i < 20; i++) tick();
        checks++; if (ce !== 1'b1 || fetch_err !== 1'b0 || stall !== 6'b000011 || pc !== 32'h4) begin
            failures++; $display("FAIL wait_forever: ce=%b err=%b st=%b pc=%h exp 1/0/000011/4", ce, fetch_err, stall, pc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_id_stall();
        test_branch();
        test_branch_idle();
        test_reset_midfetch();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
